pipelined_data_memory: RTL and testbench

PIPELINED_DATA_MEMORY -- requirements
Module: pipelined_data_memory

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/pipelined_data_memory_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/pipelined_data_memory.sv | 144 ++++++++++++++
 tb/tb_pipelined_data_memory.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory: access-size
// encodings, FSM state enum and the power-on seed values of words 0 and 1.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int unsigned SEED0 = 0;
  localparam int unsigned SEED1 = 1;

endpackage

// File: rtl/pipelined_data_memory_if.sv
// Request/response bus of the pipelined data memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// resp_valid is a one-cycle strobe with no back-pressure.
interface pipelined_data_memory_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane handling: load extraction/extension, store byte-merge
// and alignment checking for one memory word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [1:0]        lane_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o,
  output logic              align_err_o
);

  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] lane_mask;

  assign sh = {lane_i, 3'b000};

  always_comb begin
    shifted     = word_i >> sh;
    wdata_sh    = wdata_i << sh;
    load_o      = '0;
    lane_mask   = '0;
    align_err_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        load_o    = unsigned_i ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                               : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << sh;
      end
      SIZE_HALF: begin
        align_err_o = lane_i[0];
        load_o      = unsigned_i ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                 : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        lane_mask   = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh;
      end
      SIZE_WORD: begin
        align_err_o = (lane_i != 2'b00);
        load_o      = word_i;
        lane_mask   = '1;
      end
      default: align_err_o = 1'b1;
    endcase
    // Untouched lanes keep the old word contents.
    merged_o = (word_i & ~lane_mask) | (wdata_sh & lane_mask);
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Word-organised data memory with a fixed-latency request/response FSM.
// Optional probe export of a window of words when DMEM_PROBE_EN is defined.
module pipelined_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned NUM_PROBES  = 10,
  parameter int unsigned PROBE_BASE  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pipelined_data_memory_if.slave         bus,
  output state_e                         dbg_state_o
`ifdef DMEM_PROBE_EN
  ,
  output logic [NUM_PROBES*DATA_W-1:0]   probe_data
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (WAIT_STATES > 7) begin : g_bad_wait
    $error("WAIT_STATES must be 0..7");
  end
  if (PROBE_BASE + NUM_PROBES > DEPTH) begin : g_bad_probe
    $error("probe window exceeds DEPTH");
  end

  // Power-on contents; reset deliberately leaves the array alone.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{1: DATA_W'(SEED1), default: DATA_W'(SEED0)};

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              enter_resp;
  logic              op_write;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [31:0]       op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic              range_err;
  logic              align_err;
  logic              op_err;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  assign accept = bus.req_valid && (state_q == IDLE);

  // With zero wait states the access completes on the accept edge itself,
  // so the operation is taken straight from the bus rather than the latches.
  assign op_write = (state_q == IDLE) ? bus.req_write    : wr_q;
  assign op_size  = (state_q == IDLE) ? bus.req_size     : size_q;
  assign op_uns   = (state_q == IDLE) ? bus.req_unsigned : uns_q;
  assign op_addr  = (state_q == IDLE) ? bus.req_addr     : addr_q;
  assign op_wdata = (state_q == IDLE) ? bus.req_wdata    : wdata_q;

  assign enter_resp = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 3'd0));

  assign op_idx    = op_addr[IDX_W+1:2];
  assign range_err = (op_addr[31:2] >= 30'(DEPTH));
  assign op_err    = range_err || align_err;

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .size_i      (op_size),
    .unsigned_i  (op_uns),
    .lane_i      (op_addr[1:0]),
    .word_i      (mem_q[op_idx]),
    .wdata_i     (op_wdata),
    .load_o      (load_val),
    .merged_o    (merged),
    .align_err_o (align_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= enter_resp;
      resp_err_q   <= enter_resp && op_err;
      resp_rdata_q <= (enter_resp && !op_err && !op_write) ? load_val : '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q    <= bus.req_write;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= 3'(WAIT_STATES - 1);
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stores commit on the edge entering RESP; a held reset cancels them.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && op_write && !op_err) begin
      mem_q[op_idx] <= merged;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state_o    = state_q;

`ifdef DMEM_PROBE_EN
  for (genvar i = 0; i < int'(NUM_PROBES); i++) begin : g_probe
    assign probe_data[i*DATA_W +: DATA_W] = mem_q[PROBE_BASE + i];
  end
`endif

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Randomised self-checking bench for pipelined_data_memory against a
// byte-addressed reference model; probe checks when DMEM_PROBE_EN is defined.
module tb_pipelined_data_memory;
  import dmem_pkg::*;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEPTH      = 64;
  localparam int unsigned NUM_PROBES = 10;
  localparam int unsigned PROBE_BASE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_data_memory_if #(.DATA_W(DATA_W)) dif ();
  pipelined_data_memory_if #(.DATA_W(DATA_W)) dif0 ();
  state_e dbg_state;
  state_e dbg_state0;
`ifdef DMEM_PROBE_EN
  logic [NUM_PROBES*DATA_W-1:0] probe;
  logic [NUM_PROBES*DATA_W-1:0] probe0;
`endif

  pipelined_data_memory #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(1),
    .NUM_PROBES(NUM_PROBES), .PROBE_BASE(PROBE_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(dif.slave), .dbg_state_o(dbg_state)
`ifdef DMEM_PROBE_EN
    , .probe_data(probe)
`endif
  );

  pipelined_data_memory #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(0),
    .NUM_PROBES(NUM_PROBES), .PROBE_BASE(PROBE_BASE)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(dif0.slave), .dbg_state_o(dbg_state0)
`ifdef DMEM_PROBE_EN
    , .probe_data(probe0)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [7:0]  mb [DEPTH*4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mb[idx*4+3], mb[idx*4+2], mb[idx*4+1], mb[idx*4]};
  endfunction

  // Reference: byte-array memory, little-endian, access rules applied directly.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] v;
    n   = 1 << sz;
    err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
          ((addr >> 2) >= DEPTH);
    rd  = '0;
    if (err) return;
    if (wr) begin
      for (int b = 0; b < n; b++) mb[int'(addr) + b] = wd[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < n; b++) v = v | (32'(mb[int'(addr) + b]) << (8*b));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      rd = v;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    dif.req_valid = 1'b0; dif.req_write = 1'b0; dif.req_size = 2'd0;
    dif.req_unsigned = 1'b0; dif.req_addr = '0; dif.req_wdata = '0;
    dif0.req_valid = 1'b0; dif0.req_write = 1'b0; dif0.req_size = 2'd0;
    dif0.req_unsigned = 1'b0; dif0.req_addr = '0; dif0.req_wdata = '0;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] er;
    logic        ee;
    logic [32:0] exp;
    int          lat;
    model_access(wr, sz, uns, addr, wd, er, ee);
    exp_q.push_back({ee, er});
    @(negedge clk);
    check({tag, " ready"}, 64'(dif.req_ready), 64'd1);
    dif.req_valid = 1'b1; dif.req_write = wr; dif.req_size = sz;
    dif.req_unsigned = uns; dif.req_addr = addr; dif.req_wdata = wd;
    @(posedge clk); #1;
    dif.req_valid = 1'b0;
    dif.req_wdata = $urandom;
    lat = 1;
    while (!dif.resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    exp = exp_q.pop_front();
    if (!dif.resp_valid) begin
      check({tag, " timeout"}, 64'(dif.resp_valid), 64'd1);
    end else begin
      check({tag, " latency"}, 64'(lat), 64'd2);
      check({tag, " rdata"}, 64'(dif.resp_rdata), 64'(exp[31:0]));
      check({tag, " err"}, 64'(dif.resp_err), 64'(exp[32]));
      @(posedge clk); #1;
      check({tag, " strobe"}, {dif.resp_valid, dif.resp_err, 30'd0, dif.resp_rdata}, 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int resp_cnt;
    logic [1:0] sz;
    logic [31:0] addr;

    for (int i = 0; i < int'(DEPTH*4); i++) mb[i] = 8'h00;
    mb[4] = 8'h01;
    drive_idle();

    repeat (2) @(negedge clk);
    check("rst ready", 64'(dif.req_ready), 64'd1);
    check("rst outputs", {dif.resp_valid, dif.resp_err, 30'd0, dif.resp_rdata}, 64'd0);
    rst_n = 1'b1;

    do_req("seed load 0x4", 1'b0, 2'd2, 1'b0, 32'h4, '0);
    do_req("seed load 0x0", 1'b0, 2'd2, 1'b0, 32'h0, '0);
    do_req("store 0x8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    do_req("byte 0xB signed", 1'b0, 2'd0, 1'b0, 32'hB, '0);
    check("byte 0xB value", 64'(model_word(2)), 64'hDEADBEEF);
    do_req("half 0xA unsigned", 1'b0, 2'd1, 1'b1, 32'hA, '0);
    do_req("store byte 0x9", 1'b1, 2'd0, 1'b0, 32'h9, 32'h0000005A);
    do_req("word 0x8 merged", 1'b0, 2'd2, 1'b0, 32'h8, '0);
`ifdef DMEM_PROBE_EN
    check("probe word2", 64'(probe[0 +: 32]), 64'hDEADBEEF & 64'hFFFF00FF | 64'h5A00);
`endif
    do_req("err word 0x6", 1'b0, 2'd2, 1'b0, 32'h6, '0);
    do_req("err half 0x3", 1'b1, 2'd1, 1'b0, 32'h3, 32'h1111);
    do_req("err size 11", 1'b1, 2'd3, 1'b0, 32'h8, 32'h2222);
    do_req("err word 0x100", 1'b1, 2'd2, 1'b0, 32'h100, 32'h3333);
    do_req("unchanged 0x8", 1'b0, 2'd2, 1'b0, 32'h8, '0);

    // Reset while a store sits in WAIT: the store must be lost.
    @(negedge clk);
    dif.req_valid = 1'b1; dif.req_write = 1'b1; dif.req_size = 2'd2;
    dif.req_addr = 32'hC; dif.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    dif.req_valid = 1'b0;
    check("rst_wait state", 64'(dbg_state), 64'(WAIT));
    rst_n = 1'b0; #1;
    check("rst_wait ready", 64'(dif.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_wait no resp", 64'(dif.resp_valid), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    do_req("after rst 0xC", 1'b0, 2'd2, 1'b0, 32'hC, '0);

    // Randomised traffic against the model.
    for (int i = 0; i < 160; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 15));
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
    end
    for (int i = 0; i < int'(DEPTH); i += 7) do_req("sweep", 1'b0, 2'd2, 1'b0, 32'(i*4), '0);
`ifdef DMEM_PROBE_EN
    for (int i = 0; i < int'(NUM_PROBES); i++)
      check("probe final", 64'(probe[i*32 +: 32]), 64'(model_word(int'(PROBE_BASE) + i)));
`endif

    // Zero-wait instance: req_valid held high gives one accept every 2 cycles.
    @(negedge clk);
    dif0.req_valid = 1'b1; dif0.req_size = 2'd2; dif0.req_addr = 32'h4;
    acc = 0; resp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (dif0.req_ready) acc++;
      if (dif0.resp_valid) begin
        resp_cnt++;
        check("ws0 ready in RESP", 64'(dif0.req_ready), 64'd0);
        check("ws0 rdata", 64'(dif0.resp_rdata), 64'd1);
      end
      @(negedge clk);
    end
    dif0.req_valid = 1'b0;
    check("ws0 accepts", 64'(acc), 64'd10);
    check("ws0 responses", 64'(resp_cnt), 64'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
